// File: rtl/sipo_pkg.sv
// Shared constants for the 2-bit serial symbol link (serializer and collector sides).
package sipo_pkg;
  localparam int SYM_W  = 2;
  localparam int WORD_W = 16;
  localparam int PAIRS  = WORD_W / SYM_W;
  localparam int CNT_W  = $clog2(PAIRS);

  // Nominal spacing between symbols driven by the serializer.
  function automatic int sym_gap(input int tbl);
    return tbl + 2;
  endfunction
endpackage

// File: rtl/sipo_fifo2.sv
// Two-entry word FIFO; entry 0 is always the head. Push is taken when not full
// or when a pop happens on the same edge. Output is the registered head entry.
module sipo_fifo2
  import sipo_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [WORD_W-1:0] din_i,
  input  logic              pop_i,
  output logic [WORD_W-1:0] dout_o,
  output logic              full_o,
  output logic              empty_o
);

  logic [WORD_W-1:0] ent0_q, ent0_d;
  logic [WORD_W-1:0] ent1_q, ent1_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              pop;
  logic              push;

  assign pop  = pop_i && (cnt_q != 2'd0);
  assign push = push_i && ((cnt_q != 2'd2) || pop);

  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q;
    case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) ent0_d = din_i;
        else               ent1_d = din_i;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        ent0_d = ent1_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        // Count is unchanged; the new word goes behind whatever remains.
        if (cnt_q == 2'd1) begin
          ent0_d = din_i;
        end else begin
          ent0_d = ent1_q;
          ent1_d = din_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      cnt_q  <= cnt_d;
    end
  end

  assign dout_o  = ent0_q;
  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);

endmodule

// File: rtl/sipo_collect.sv
// Collects 8 two-bit symbols (first symbol -> word bits [15:14]) into a 16-bit word, queued 2 deep.
// Define SIPO_TIMEOUT_EN to discard a partial word after TIMEOUT idle cycles between symbols.
module sipo_collect
  import sipo_pkg::*;
#(
  parameter int TBL     = 15,
  parameter int TIMEOUT = 2 * sym_gap(TBL)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [SYM_W-1:0]  data_serial_i,
  input  logic              valid_serial_i,
  output logic [WORD_W-1:0] data_parallel_o,
  output logic              valid_parallel_o,
  input  logic              ready_i,
  output logic              overflow_o,
  output logic              timeout_o,
  output logic              busy_o
);

  // A timeout shorter than the nominal spacing would tear up normal traffic.
  if (TIMEOUT < sym_gap(TBL)) begin : g_bad_timeout
    $error("sipo_collect: TIMEOUT shorter than the nominal symbol spacing");
  end

  logic [WORD_W-SYM_W-1:0] sh_q, sh_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    overflow_q, overflow_d;
  logic                    push;
  logic                    pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [WORD_W-1:0]       word;

`ifdef SIPO_TIMEOUT_EN
  localparam int GAP_W = $clog2(TIMEOUT + 1);
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             timeout_q, timeout_d;
`endif

  assign word = {sh_q, data_serial_i};
  assign push = valid_serial_i && (cnt_q == CNT_W'(PAIRS - 1));
  assign pop  = !fifo_empty && ready_i;

  always_comb begin
    sh_d       = sh_q;
    cnt_d      = cnt_q;
    overflow_d = push && fifo_full && !pop;
    if (valid_serial_i) begin
      sh_d  = word[WORD_W-SYM_W-1:0];
      cnt_d = push ? '0 : cnt_q + 1'b1;
    end
`ifdef SIPO_TIMEOUT_EN
    gap_d     = gap_q;
    timeout_d = 1'b0;
    if (valid_serial_i) begin
      gap_d = '0;
    end else if (cnt_q != '0) begin
      // Last allowed idle cycle with no symbol: drop the partial word now.
      if (gap_q == GAP_W'(TIMEOUT - 1)) begin
        sh_d      = '0;
        cnt_d     = '0;
        gap_d     = '0;
        timeout_d = 1'b1;
      end else begin
        gap_d = gap_q + 1'b1;
      end
    end else begin
      gap_d = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q       <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
`ifdef SIPO_TIMEOUT_EN
      gap_q      <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      sh_q       <= sh_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
`ifdef SIPO_TIMEOUT_EN
      gap_q      <= gap_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  sipo_fifo2 u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .din_i   (word),
    .pop_i   (pop),
    .dout_o  (data_parallel_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign valid_parallel_o = !fifo_empty;
  assign overflow_o       = overflow_q;
  assign busy_o           = (cnt_q != '0);
`ifdef SIPO_TIMEOUT_EN
  assign timeout_o        = timeout_q;
`else
  assign timeout_o        = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_collect.sv
// Directed bench for sipo_collect: a vector table of words/spacings plus queue, timeout and reset sequences.
module tb_sipo_collect;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  data_serial_i;
  logic        valid_serial_i;
  logic [15:0] data_parallel_o;
  logic        valid_parallel_o;
  logic        ready_i;
  logic        overflow_o;
  logic        timeout_o;
  logic        busy_o;

  int n_cmp  = 0;
  int n_fail = 0;

  sipo_collect dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .data_serial_i    (data_serial_i),
    .valid_serial_i   (valid_serial_i),
    .data_parallel_o  (data_parallel_o),
    .valid_parallel_o (valid_parallel_o),
    .ready_i          (ready_i),
    .overflow_o       (overflow_o),
    .timeout_o        (timeout_o),
    .busy_o           (busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] word;
    int          spacing;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are observed on the falling edge too.
  task automatic drive(input logic v, input logic [1:0] s);
    @(negedge clk);
    valid_serial_i = v;
    data_serial_i  = s;
  endtask

  task automatic send_part(input logic [15:0] w, input int first, input int n);
    for (int i = first; i < first + n; i++) drive(1'b1, w[15-2*i -: 2]);
  endtask

  task automatic send_word(input logic [15:0] w, input int spacing);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, w[15-2*i -: 2]);
      if (i < 7) repeat (spacing - 1) drive(1'b0, 2'd0);
    end
  endtask

  initial begin
    int first_k;
    int pulses;
    logic busy_at_35;

    vecs[0] = '{16'hA5C3, 17};
    vecs[1] = '{16'hCC66, 1};
    vecs[2] = '{16'hFFFF, 1};
    vecs[3] = '{16'h0000, 2};
    vecs[4] = '{16'h8001, 3};
    vecs[5] = '{16'h7E81, 34};

    rst_n = 1'b0;
    valid_serial_i = 1'b0;
    data_serial_i = 2'd0;
    ready_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset valid", {31'd0, valid_parallel_o}, 32'd0);
    chk("reset data", {16'd0, data_parallel_o}, 32'd0);
    chk("reset overflow", {31'd0, overflow_o}, 32'd0);
    chk("reset timeout", {31'd0, timeout_o}, 32'd0);
    chk("reset busy", {31'd0, busy_o}, 32'd0);
    rst_n = 1'b1;

    // Vector table, sink always ready.
    ready_i = 1'b1;
    for (int v = 0; v < 6; v++) begin
      send_word(vecs[v].word, vecs[v].spacing);
      drive(1'b0, 2'd0);
      chk($sformatf("vec%0d valid", v), {31'd0, valid_parallel_o}, 32'd1);
      chk($sformatf("vec%0d data", v), {16'd0, data_parallel_o}, {16'd0, vecs[v].word});
      chk($sformatf("vec%0d busy", v), {31'd0, busy_o}, 32'd0);
      drive(1'b0, 2'd0);
      chk($sformatf("vec%0d popped", v), {31'd0, valid_parallel_o}, 32'd0);
    end

    // Overflow: three words into a stalled two-entry queue.
    ready_i = 1'b0;
    send_word(16'h1111, 1);
    drive(1'b0, 2'd0);
    chk("ovf w1 data", {16'd0, data_parallel_o}, 32'h1111);
    chk("ovf w1 no pulse", {31'd0, overflow_o}, 32'd0);
    send_word(16'h2222, 1);
    drive(1'b0, 2'd0);
    chk("ovf w2 no pulse", {31'd0, overflow_o}, 32'd0);
    send_word(16'h3333, 1);
    drive(1'b0, 2'd0);
    chk("ovf w3 pulse", {31'd0, overflow_o}, 32'd1);
    chk("ovf head held", {16'd0, data_parallel_o}, 32'h1111);
    drive(1'b0, 2'd0);
    chk("ovf pulse ends", {31'd0, overflow_o}, 32'd0);
    chk("ovf head pop1", {16'd0, data_parallel_o}, 32'h1111);
    ready_i = 1'b1;
    drive(1'b0, 2'd0);
    chk("ovf head pop2", {16'd0, data_parallel_o}, 32'h2222);
    chk("ovf valid pop2", {31'd0, valid_parallel_o}, 32'd1);
    drive(1'b0, 2'd0);
    chk("ovf empty", {31'd0, valid_parallel_o}, 32'd0);

    // Full queue with a pop on the same edge as the third push.
    ready_i = 1'b0;
    send_word(16'h1111, 1);
    send_word(16'h2222, 1);
    send_part(16'h3333, 0, 7);
    drive(1'b1, 2'b11);
    ready_i = 1'b1;
    drive(1'b0, 2'd0);
    chk("pp no overflow", {31'd0, overflow_o}, 32'd0);
    chk("pp head 2222", {16'd0, data_parallel_o}, 32'h2222);
    drive(1'b0, 2'd0);
    chk("pp head 3333", {16'd0, data_parallel_o}, 32'h3333);
    chk("pp valid 3333", {31'd0, valid_parallel_o}, 32'd1);
    drive(1'b0, 2'd0);
    chk("pp empty", {31'd0, valid_parallel_o}, 32'd0);

    // Partial word followed by a long idle gap.
    send_part(16'hE400, 0, 3);
    first_k = -1;
    pulses = 0;
    busy_at_35 = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      drive(1'b0, 2'd0);
      if (timeout_o) begin
        pulses++;
        if (first_k < 0) first_k = k;
      end
      if (k == 35) busy_at_35 = busy_o;
    end
`ifdef SIPO_TIMEOUT_EN
    chk("to pulse count", pulses, 32'd1);
    chk("to pulse cycle", first_k, 32'd35);
    chk("to busy cleared", {31'd0, busy_at_35}, 32'd0);
    send_word(16'h5A96, 1);
    drive(1'b0, 2'd0);
    chk("to next word", {16'd0, data_parallel_o}, 32'h5A96);
`else
    chk("to pulse count", pulses, 32'd0);
    chk("to busy held", {31'd0, busy_at_35}, 32'd1);
    send_part(16'h5A96, 0, 5);
    drive(1'b0, 2'd0);
    chk("to held word", {16'd0, data_parallel_o}, 32'hE56A);
`endif
    chk("to word valid", {31'd0, valid_parallel_o}, 32'd1);
    chk("to busy after", {31'd0, busy_o}, 32'd0);
    drive(1'b0, 2'd0);

    // Asynchronous reset with a queued word and a half-built word.
    ready_i = 1'b0;
    send_word(16'h0F0F, 1);
    send_part(16'h3C96, 0, 4);
    drive(1'b0, 2'd0);
    chk("rst pre valid", {31'd0, valid_parallel_o}, 32'd1);
    chk("rst pre busy", {31'd0, busy_o}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst valid", {31'd0, valid_parallel_o}, 32'd0);
    chk("rst data", {16'd0, data_parallel_o}, 32'd0);
    chk("rst busy", {31'd0, busy_o}, 32'd0);
    chk("rst overflow", {31'd0, overflow_o}, 32'd0);
    chk("rst timeout", {31'd0, timeout_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ready_i = 1'b1;
    send_word(16'h3C96, 1);
    drive(1'b0, 2'd0);
    chk("rst clean valid", {31'd0, valid_parallel_o}, 32'd1);
    chk("rst clean data", {16'd0, data_parallel_o}, 32'h3C96);
    drive(1'b0, 2'd0);
    chk("rst clean popped", {31'd0, valid_parallel_o}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
